// File: rtl/mb32_booth_enc_if.sv
// Operand/result bundle for the radix-8 Booth encoder.
// master drives operands and out_ready; slave is the encoder.
interface mb32_booth_enc_if #(
    parameter int WIDTH = 32
);
    localparam int GC = (WIDTH >> 2) + 3;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [GC-1:0]    s;
    logic [GC-1:0]    d;
    logic [GC-1:0]    t;
    logic [GC-1:0]    q;
    logic [GC-1:0]    n;
    logic [WIDTH-1:0] my;
    logic [WIDTH+1:0] tmy;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid,
        input  s, d, t, q, n, my, tmy
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid,
        output s, d, t, q, n, my, tmy
    );
endinterface

// File: rtl/mb32_booth_enc.sv
// Two-stage radix-8 Booth recoder with 3*y precompute.
// Define MB32_BOOTH_SIGNED_EN for two's-complement operands.
module mb32_booth_enc #(
    parameter int WIDTH = 32
) (
    input  logic            CLK,
    input  logic            RST,
    mb32_booth_enc_if.slave bus
);
    localparam int GC = (WIDTH >> 2) + 3;
    localparam int XW = GC * 3 + 1;
    localparam int LW = WIDTH / 2;
    localparam int HW = WIDTH - LW;

    logic             s1_v;
    logic [WIDTH-1:0] s1_x;
    logic [WIDTH-1:0] s1_y;
    logic [LW+1:0]    s1_lo;

    logic             s1_adv;
    logic             s2_adv;
    logic [LW+1:0]    lo_sum;
    logic [HW+1:0]    yh_ext;
    logic [HW+1:0]    hi_sum;
    logic             ext;
    logic [XW-1:0]    xe;

    logic [GC-1:0]    s_c;
    logic [GC-1:0]    d_c;
    logic [GC-1:0]    t_c;
    logic [GC-1:0]    q_c;
    logic [GC-1:0]    n_c;

    assign s2_adv       = !bus.out_valid || bus.out_ready;
    assign s1_adv       = !s1_v || s2_adv;
    assign bus.in_ready = !RST && s1_adv;

    assign lo_sum = ({2'b00, bus.y[LW-1:0]} << 1)
                  + {2'b00, bus.y[LW-1:0]};

`ifdef MB32_BOOTH_SIGNED_EN
    assign ext    = s1_x[WIDTH-1];
    assign yh_ext = {{2{s1_y[WIDTH-1]}}, s1_y[WIDTH-1:LW]};
`else
    assign ext    = 1'b0;
    assign yh_ext = {2'b00, s1_y[WIDTH-1:LW]};
`endif

    // the low half's two carry bits fold into the upper half here
    assign hi_sum = (yh_ext << 1) + yh_ext
                  + {{HW{1'b0}}, s1_lo[LW+1:LW]};

    always_comb begin
        xe          = {XW{ext}};
        xe[WIDTH:1] = s1_x;
        xe[0]       = 1'b0;
    end

    always_comb begin
        s_c = '0;
        d_c = '0;
        t_c = '0;
        q_c = '0;
        n_c = '0;
        for (int i = 0; i < GC; i++) begin
            case (xe[3*i +: 4])
                4'b0001, 4'b0010,
                4'b1101, 4'b1110: s_c[i] = 1'b1;
                4'b0011, 4'b0100,
                4'b1011, 4'b1100: d_c[i] = 1'b1;
                4'b0101, 4'b0110,
                4'b1001, 4'b1010: t_c[i] = 1'b1;
                4'b0111, 4'b1000: q_c[i] = 1'b1;
                default:          ;
            endcase
            n_c[i] = xe[3*i+3] && (xe[3*i +: 4] != 4'b1111);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_v  <= 1'b0;
            s1_x  <= '0;
            s1_y  <= '0;
            s1_lo <= '0;
        end else if (s1_adv) begin
            s1_v <= bus.in_valid;
            if (bus.in_valid) begin
                s1_x  <= bus.x;
                s1_y  <= bus.y;
                s1_lo <= lo_sum;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.out_valid <= 1'b0;
            bus.s         <= '0;
            bus.d         <= '0;
            bus.t         <= '0;
            bus.q         <= '0;
            bus.n         <= '0;
            bus.my        <= '0;
            bus.tmy       <= '0;
        end else if (s2_adv) begin
            bus.out_valid <= s1_v;
            if (s1_v) begin
                bus.s   <= s_c;
                bus.d   <= d_c;
                bus.t   <= t_c;
                bus.q   <= q_c;
                bus.n   <= n_c;
                bus.my  <= s1_y;
                bus.tmy <= {hi_sum, s1_lo[LW-1:0]};
            end
        end
    end
endmodule

// File: doc/mb32_booth_enc.md
MB32_BOOTH_ENC -- requirements
Module: mb32_booth_enc

Interface
REQ-001 Parameter WIDTH, default 32, sets operand width; group count GC = (WIDTH>>2)+3, which is 11 at the default.
REQ-002 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 RST  input  1  reset; synchronous and active-high.
REQ-004 in_valid  input  1  an operand pair is offered on x/y.
REQ-005 in_ready  output  1  the block accepts x/y this cycle.
REQ-006 x  input  WIDTH  multiplier operand, Booth-recoded.
REQ-007 y  input  WIDTH  multiplicand operand.
REQ-008 out_valid  output  1  s/d/t/q/n/my/tmy hold a valid encoded operation.
REQ-009 out_ready  input  1  the downstream multiplier stage consumes the outputs this cycle.
REQ-010 s, d, t, q, n  output  GC each  per-group one-hot select for x1/x2/x3/x4 and the negate flag.
REQ-011 my  output  WIDTH  registered copy of y.
REQ-012 tmy  output  WIDTH+2  registered 3*y.

Function
REQ-013 Transfer rules: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
REQ-014 Pipeline has 2 stages (S1, S2); latency from acceptance to out_valid is exactly 2 cycles when not stalled.
REQ-015 S1 registers x and y, the low half-sum y[WIDTH/2-1:0]*3, and its carry.
REQ-016 S2 completes the upper half of 3*y using the S1 carry, performs the Booth recode, and drives all outputs.
REQ-017 S2 advance condition: !out_valid || out_ready.
REQ-018 S1 advance condition: S1 empty || S2 advances.
REQ-019 in_ready = S1 empty || S2 advances; this is a combinational path from out_ready.
REQ-020 Full throughput: one operation per cycle while out_ready = 1.
REQ-021 During a stall, all outputs and S1 contents are held bit-stable and no operation is dropped or duplicated.
REQ-022 Extended operand xe has GC*3+1 bits:
- xe[0] = 0
- xe[WIDTH:1] = x
- upper bits = extension bit (see REQ-033/034)
REQ-023 Group i (0..GC-1) uses bits b2 b1 b0 b-1 = xe[3i+3:3i].
REQ-024 Digit value = -4*b2 + 2*b1 + b0 + b-1.
REQ-025 Digit mapping:
- 0000 and 1111 give 0
- 0001 and 0010 give +1
- 0011 and 0100 give +2
- 0101 and 0110 give +3
- 0111 gives +4
- 1000 gives -4
- 1001 and 1010 give -3
- 1011 and 1100 give -2
- 1101 and 1110 give -1
REQ-026 Magnitude select: |1| sets s[i], |2| sets d[i], |3| sets t[i], |4| sets q[i]; at most one of these is set per group.
REQ-027 n[i] = 1 only for negative digits; a zero digit drives all five bits of group i to 0.
REQ-028 tmy = 3*y computed exactly in WIDTH+2 bits with no truncation.
REQ-029 While out_valid = 0, outputs hold their last values; the downstream stage ignores them.

Reset
REQ-030 When RST is high at a clock edge:
- out_valid and the S1 valid flag clear to 0
- s, d, t, q, n, my, tmy clear to 0
- in-flight operations are discarded
REQ-031 in_ready is 0 while RST is high and 1 in the first cycle after RST deasserts.
REQ-032 If RST and an input handshake coincide, reset wins and the input is not accepted.

Configuration
REQ-033 With macro MB32_BOOTH_SIGNED_EN defined:
- x and y are two's complement
- the xe extension bits are x[WIDTH-1]
- tmy is the sign-extended 3*y
REQ-034 Without MB32_BOOTH_SIGNED_EN:
- operands are unsigned
- the xe extension bits are 0
- tmy is the zero-extended 3*y

Verification
REQ-035 Single transfer: x=0x00000007, y=5 with out_ready=1 -> two cycles later out_valid=1, s=0x003, n=0x001, d=t=q=0, my=5, tmy=15.
REQ-036 Unsigned build: x=0xFFFFFFFF, y=0xFFFFFFFF -> s=0x001, q=0x400, n=0x001, tmy=0x2FFFFFFFD.
REQ-037 Signed build: x=0xFFFFFFFF, y=0xFFFFFFFF -> s=0x001, n=0x001, q=0, tmy=0x3FFFFFFFD.
REQ-038 Backpressure: offer 3 back-to-back operands with out_ready=0 -> exactly 2 accepted, in_ready=0 until out_ready=1; all 3 then emerge in order with no loss or duplication.
REQ-039 Throughput: stream 100 random operands with out_ready=1 -> one result per cycle; a software model reconstructing sum(digit_i*8^i)*y equals x*y.
REQ-040 Reset mid-flight: assert RST with both stages full -> the next cycle has out_valid=0, all outputs 0, in_ready=1; no stale result appears afterwards.
